// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard.
//   - forwarding select encodings (FWD_RF/E/M/W)
//   - scoreboard entry struct (destination + cycles-until-ready)
//   - default Tnew/Tuse values for the common instruction classes
//   - saturating Tnew decrement helper
package hazard_scoreboard_pkg;

   // Entry fields are stored at these widths. The top-level AW/TW parameters
   // are zero-extended into them, so AW <= SB_AW and TW <= SB_TW must hold.
   localparam int SB_AW = 8;
   localparam int SB_TW = 4;

   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_E  = 2'd1;
   localparam logic [1:0] FWD_M  = 2'd2;
   localparam logic [1:0] FWD_W  = 2'd3;

   typedef struct packed {
      logic [SB_AW-1:0] dst;   // 0 = writes nothing
      logic [SB_TW-1:0] tnew;  // cycles until result can be forwarded
   } sb_entry_t;

   localparam sb_entry_t SB_BUBBLE = '{default: '0};

   // Default Tnew (producer) values
   localparam int TNEW_ALU  = 1;
   localparam int TNEW_LOAD = 2;
   localparam int TNEW_LINK = 0;
   // Default Tuse (consumer) values
   localparam int TUSE_ALU      = 1;
   localparam int TUSE_BRANCH   = 0;
   localparam int TUSE_JR       = 0;
   localparam int TUSE_STORE_RT = 2;

   function automatic logic [SB_TW-1:0] tnew_dec(input logic [SB_TW-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy_ctr.sv
// Mul/div occupancy tracker.
//   clk, reset    : clock, synchronous active-high reset
//   stall         : D instruction is being held this cycle
//   md_start      : D instruction starts a mult/div
//   md_div        : with md_start, 1 = divide
//   md_busy       : registered "counter was nonzero" flag
//   md_inflight   : E holds an md-start issued last cycle
// md_busy lags the counter by one edge, so the cycle directly after issue is
// covered by md_inflight instead; together they hold HI/LO users for LAT+1
// cycles.
module md_busy_ctr
   import hazard_scoreboard_pkg::*;
#(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic stall,
   input  logic md_start,
   input  logic md_div,
   output logic md_busy,
   output logic md_inflight
);

   localparam int CW = $clog2(DIV_LAT + 1);

   logic [CW-1:0] cnt;
   logic          issue;

   // A stalled start does not touch the counter; it retries next cycle.
   assign issue = md_start & ~stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         md_busy     <= 1'b0;
         md_inflight <= 1'b0;
      end else begin
         md_busy     <= (cnt != '0);
         md_inflight <= issue;
         if (issue)
            cnt <= md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
         else if (cnt != '0)
            cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard for a 5-stage pipeline (D, E, M, W).
//   clk, reset             : clock, synchronous active-high reset
//   d_rs/d_rt (+_use,tuse) : D-stage sources, whether read, cycles until use
//   d_dst, d_tnew          : D-stage destination (0 = none) and its Tnew
//   d_md_start/div/use     : mult/div start, divide select, HI/LO access
//   stall                  : hold PC/IR_D, bubble into E
//   fwd_rs_d/fwd_rt_d      : D operand select (RF/E/M/W)
//   fwd_rs_e/fwd_rt_e      : E operand select (pipe/M/W)
//   fwd_rt_m               : M store data select (pipe/W)
//   md_busy                : mul/div unit occupied
// All outputs except md_busy are combinational from current entries and D.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int AW      = 5,
   parameter int TW      = 2,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] d_rs,
   input  logic [AW-1:0] d_rt,
   input  logic          d_rs_use,
   input  logic          d_rt_use,
   input  logic [TW-1:0] d_tuse_rs,
   input  logic [TW-1:0] d_tuse_rt,
   input  logic [AW-1:0] d_dst,
   input  logic [TW-1:0] d_tnew,
   input  logic          d_md_start,
   input  logic          d_md_div,
   input  logic          d_md_use,
   output logic          stall,
   output logic [1:0]    fwd_rs_d,
   output logic [1:0]    fwd_rt_d,
   output logic [1:0]    fwd_rs_e,
   output logic [1:0]    fwd_rt_e,
   output logic [1:0]    fwd_rt_m,
   output logic          md_busy
);

   sb_entry_t     e_q, m_q, w_q;
   logic [AW-1:0] e_rs_q, e_rt_q, m_rt_q;
   logic          md_inflight;
   logic          stall_rs, stall_rt, stall_md;

   // dst==0 never matches, which also keeps $0 reads out of every path.
   function automatic logic hit(input sb_entry_t ent, input logic [AW-1:0] r);
      return (ent.dst != '0) && (ent.dst == SB_AW'(r));
   endfunction

   function automatic logic late(input sb_entry_t ent, input logic [AW-1:0] r,
                                 input logic [TW-1:0] tuse);
      return hit(ent, r) && (ent.tnew > SB_TW'(tuse));
   endfunction

   // Youngest matching stage decides; if it is not ready yet, read the
   // normal source rather than an older (stale) producer.
   function automatic logic [1:0] fwd_pick(input sb_entry_t e, input sb_entry_t m,
                                           input sb_entry_t w, input logic [AW-1:0] r);
      logic [1:0] sel;
      sel = FWD_RF;
      if (hit(e, r))
         sel = (e.tnew == '0) ? FWD_E : FWD_RF;
      else if (hit(m, r))
         sel = (m.tnew == '0) ? FWD_M : FWD_RF;
      else if (hit(w, r))
         sel = (w.tnew == '0) ? FWD_W : FWD_RF;
      return sel;
   endfunction

   always_comb begin
      stall_rs = d_rs_use && (d_rs != '0) &&
                 (late(e_q, d_rs, d_tuse_rs) || late(m_q, d_rs, d_tuse_rs));
      stall_rt = d_rt_use && (d_rt != '0) &&
                 (late(e_q, d_rt, d_tuse_rt) || late(m_q, d_rt, d_tuse_rt));
      stall_md = (d_md_start || d_md_use) && (md_busy || md_inflight);
      stall    = stall_rs || stall_rt || stall_md;

      fwd_rs_d = fwd_pick(e_q, m_q, w_q, d_rs);
      fwd_rt_d = fwd_pick(e_q, m_q, w_q, d_rt);
      fwd_rs_e = fwd_pick(SB_BUBBLE, m_q, w_q, e_rs_q);
      fwd_rt_e = fwd_pick(SB_BUBBLE, m_q, w_q, e_rt_q);
      fwd_rt_m = fwd_pick(SB_BUBBLE, SB_BUBBLE, w_q, m_rt_q);
   end

   // E takes D (or a bubble on stall); M and W always advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_q    <= SB_BUBBLE;
         m_q    <= SB_BUBBLE;
         w_q    <= SB_BUBBLE;
         e_rs_q <= '0;
         e_rt_q <= '0;
         m_rt_q <= '0;
      end else begin
         if (stall) begin
            e_q    <= SB_BUBBLE;
            e_rs_q <= '0;
            e_rt_q <= '0;
         end else begin
            e_q.dst  <= SB_AW'(d_dst);
            e_q.tnew <= SB_TW'(d_tnew);
            e_rs_q   <= d_rs;
            e_rt_q   <= d_rt;
         end
         m_q.dst  <= e_q.dst;
         m_q.tnew <= tnew_dec(e_q.tnew);
         m_rt_q   <= e_rt_q;
         w_q.dst  <= m_q.dst;
         w_q.tnew <= tnew_dec(m_q.tnew);
      end
   end

   md_busy_ctr #(
      .MUL_LAT(MUL_LAT),
      .DIV_LAT(DIV_LAT)
   ) u_md_busy_ctr (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .md_start   (d_md_start),
      .md_div     (d_md_div),
      .md_busy    (md_busy),
      .md_inflight(md_inflight)
   );

endmodule
